// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration register file: command layout,
// frame FSM states and the FM transmitter register map.
package spi_cfg_pkg;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

  localparam int ACC_INC_LO  = 0;
  localparam int ACC_INC_MID = 1;
  localparam int ACC_INC_HI  = 2;
  localparam int DF_INC_LO   = 3;
  localparam int DF_INC_HI   = 4;
  localparam int DAC_ENA     = 5;
  localparam int DITH_CTRL   = 6;
  localparam int FLAGS       = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus rise/fall detection
// against a third flop.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_config_regs.sv
// Addressed SPI (mode 0) configuration register file with shadow staging,
// atomic commit on CSn deassert, burst auto-increment and read-back.
module spi_config_regs
  import spi_cfg_pkg::*;
#(
  parameter int                   NREG      = 8,
  parameter int                   RW        = 8,
  parameter logic [NREG*RW-1:0]   RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_clk,
  input  logic                 spi_csn,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [NREG*RW-1:0]   cfg_out,
  output logic                 cfg_update,
  output logic                 frame_err,
  output logic [1:0]           o_dbg_state
);

  localparam int             AW        = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int             BCW       = 6;
  localparam logic [BCW-1:0] CMD_LAST  = BCW'(CMD_BITS - 1);
  localparam logic [BCW-1:0] WORD_LAST = BCW'(RW - 1);
  localparam logic [7:0]     NREG_L    = 8'(NREG);
  localparam logic [6:0]     ADDR_LAST = 7'(NREG - 1);

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NREG_L;
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    return (a == ADDR_LAST) ? 7'd0 : a + 7'd1;
  endfunction

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_lvl;
  logic w_csn_sync, w_csn_rise, w_csn_fall;
  logic w_mosi_sync, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(spi_clk),
    .o_sync(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .i_async(spi_csn),
    .o_sync(w_csn_sync), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(spi_mosi),
    .o_sync(w_mosi_sync), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  spi_state_t             r_state;
  logic [BCW-1:0]         r_bit_cnt;
  logic [CMD_BITS-2:0]    r_cmd;
  logic [RW-2:0]          r_rx_shift;
  logic [RW-1:0]          r_tx_shift;
  logic [6:0]             r_addr;
  logic                   r_is_read;
  logic [NREG-1:0]        r_dirty;
  logic [RW-1:0]          r_shadow [NREG];
  logic [RW-1:0]          r_cfg    [NREG];
  logic                   r_miso;
  logic                   r_update;
  logic                   r_ferr;
  logic                   r_armed;
  logic [1:0]             r_settle;

  logic [CMD_BITS-1:0]    w_cmd_full;
  logic [6:0]             w_cmd_addr;
  logic [6:0]             w_addr_nxt;
  logic [RW-1:0]          w_rx_full;
  logic [RW-1:0]          w_rd_cmd;
  logic [RW-1:0]          w_rd_next;

  assign w_cmd_full = {r_cmd, w_mosi_sync};
  assign w_cmd_addr = w_cmd_full[CMD_ADDR_MSB:0];
  assign w_addr_nxt = next_addr(r_addr);
  assign w_rx_full  = {r_rx_shift, w_mosi_sync};
  assign w_rd_cmd   = in_range(w_cmd_addr) ? r_cfg[w_cmd_addr[AW-1:0]] : '0;
  assign w_rd_next  = in_range(w_addr_nxt) ? r_cfg[w_addr_nxt[AW-1:0]] : '0;

  // A reset inside a frame leaves CSn low; the frame is only armed again once
  // the synchronizer holds real samples and CSn has been seen high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_cmd      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_addr     <= '0;
      r_is_read  <= 1'b0;
      r_dirty    <= '0;
      r_miso     <= 1'b0;
      r_update   <= 1'b0;
      r_ferr     <= 1'b0;
      r_armed    <= 1'b0;
      r_settle   <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_cfg[i]    <= RESET_VAL[i*RW +: RW];
        r_shadow[i] <= RESET_VAL[i*RW +: RW];
      end
    end else begin
      r_update <= 1'b0;
      r_ferr   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_armed) begin
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
            else if (w_csn_sync)  r_armed  <= 1'b1;
          end else if (w_csn_fall) begin
            r_state   <= CMD;
            r_bit_cnt <= '0;
          end
        end
        CMD: begin
          if (w_csn_rise) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_ferr    <= (r_bit_cnt != '0);
          end else if (w_sclk_rise) begin
            r_cmd <= w_cmd_full[CMD_BITS-2:0];
            if (r_bit_cnt == CMD_LAST) begin
              r_state    <= DATA;
              r_bit_cnt  <= '0;
              r_is_read  <= w_cmd_full[CMD_RW_BIT];
              r_addr     <= w_cmd_addr;
              r_tx_shift <= w_rd_cmd;
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end
        end
        DATA: begin
          if (w_csn_rise) begin
            // Only write frames can mark registers dirty, so this is the commit.
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_ferr    <= (r_bit_cnt != '0);
            r_update  <= |r_dirty;
            r_dirty   <= '0;
            for (int i = 0; i < NREG; i++) begin
              if (r_dirty[i]) r_cfg[i] <= r_shadow[i];
            end
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_full[RW-2:0];
            if (r_bit_cnt == WORD_LAST) begin
              r_bit_cnt  <= '0;
              r_addr     <= w_addr_nxt;
              r_tx_shift <= w_rd_next;
              if (!r_is_read && in_range(r_addr)) begin
                r_shadow[r_addr[AW-1:0]] <= w_rx_full;
                r_dirty[r_addr[AW-1:0]]  <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
          end else if (w_sclk_fall && r_is_read) begin
            r_miso     <= r_tx_shift[RW-1];
            r_tx_shift <= {r_tx_shift[RW-2:0], 1'b0};
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_csn_sync) r_miso <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cfg_out
    assign cfg_out[gi*RW +: RW] = r_cfg[gi];
  end

  assign spi_miso    = r_miso;
  assign cfg_update  = r_update;
  assign frame_err   = r_ferr;
  assign o_dbg_state = r_state;

endmodule

// File: doc/spi_config_regs.md
Name: spi_config_regs

Overview:
- Addressed, parametrised SPI configuration register file for the FM transmitter, successor to the flat shift-register config block.
- SPI (mode 0) is oversampled in the system clock domain. Writes stage into shadow registers and are committed atomically on CSn deassert, so config outputs never toggle during loading.
- Supports read-back, burst auto-increment and per-register reset defaults. Outputs feed the NCO, FM modulator, DAC-enable and dither logic.

Parameters:
- NREG, 8, number of config registers (1..128).
- RW, 8, register width in bits (4..32).
- AW, $clog2(NREG), address width, derived, not overridable.
- RESET_VAL, {NREG*RW{1'b0}}, packed reset/default values; register i is RESET_VAL[i*RW +: RW].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- spi_clk  in  1  SPI SCLK, asynchronous, CPOL=0.
- spi_csn  in  1  SPI chip select, active-low, asynchronous.
- spi_mosi  in  1  SPI data in, asynchronous.
- spi_miso  out  1  SPI data out, registered on clk.
- cfg_out  out  NREG*RW  committed register values, packed, register i at [i*RW +: RW].
- cfg_update  out  1  one-clk pulse when a commit changes cfg_out.
- frame_err  out  1  one-clk pulse on CSn deassert when the frame ended mid-word.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - cfg_out and shadow = RESET_VAL.
  - spi_miso=0, cfg_update=0, frame_err=0.
  - FSM=IDLE, all counters 0, synchronizers cleared (spi_csn sync = 1).
  - Reset mid-frame aborts the frame; staged data is discarded.
- Input sync:
  - spi_clk, spi_csn and spi_mosi each pass through a 2-FF synchronizer.
  - Edges are detected by comparing with a third FF.
  - Rise/fall of SCLK is detected 3 clk after the pin edge.
  - Requirement: f_sclk <= f_clk/8, SCLK high and low each >= 3 clk.
- Frame format, MSB first:
  - Byte 0 is the command: bit7 = R/Wn (1 = read), bits[6:0] = start address.
  - Then RW-bit data words follow. The address auto-increments after each complete word and wraps NREG-1 -> 0.
- FSM: IDLE -> CMD on CSn fall. CMD -> DATA after the 8th SCLK rise. DATA -> DATA on each word boundary. Any state -> IDLE on CSn rise.
- SCLK edges while CSn is high are ignored.
- Counters: bit_cnt counts 0..7 in CMD and 0..RW-1 in DATA.
- Write:
  - mosi_sync is sampled on each SCLK rise into rx_shift.
  - On the RW-th bit, shadow[addr] <= rx_shift and the dirty[addr] bit is set, but only if addr < NREG.
  - Out-of-range addresses are ignored but still increment.
- Commit:
  - Happens on the clk after CSn rise is detected, and only for a write frame with at least one complete word.
  - cfg_out[i] <= shadow[i] for every dirty i, then all dirty bits are cleared.
  - cfg_update pulses that same cycle if any dirty bit was set.
- Partial word at CSn rise: the partial word is discarded, complete words are still committed, and frame_err pulses (simultaneously with cfg_update if both apply).
- Read:
  - At the 8th SCLK rise of CMD, tx_shift <= cfg_out[addr], or 0 if out of range.
  - spi_miso <= tx_shift MSB on each SCLK fall, then tx_shift shifts left.
  - At each word boundary in DATA, tx_shift reloads from the next address.
  - Reads return committed values. Shadow is not visible, and read frames never commit.
- spi_miso is forced to 0 while CSn is high, within 3 clk of the pin rising.
- CSn fall during an active frame (glitch with no rise seen) cannot occur by construction; a CSn rise always ends the frame first.

Decomposition:
- Shared package spi_cfg_pkg holds:
  - Command bit positions (CMD_RW_BIT=7, CMD_ADDR_MSB=6).
  - CMD_BITS=8.
  - FSM state enum {IDLE, CMD, DATA}.
  - Register index constants for the transmitter map: ACC_INC_LO/MID/HI, DF_INC_LO/HI, DAC_ENA, DITH_CTRL, FLAGS.
- One sub-module is natural: spi_sync_edge, a 2-FF synchronizer plus rise/fall detector, instanced three times.

Test Plan (NREG=8, RW=8, RESET_VAL reg i = 8'h10+i, f_sclk = f_clk/10):
- Reset release, no SPI -> cfg_out reg i = 8'h10+i, spi_miso=0, no cfg_update pulse.
- Write frame cmd 8'h02 + data 8'hA5 -> cfg_out reg 2 unchanged during the frame; 8'hA5 one clk after CSn rise is detected; single cfg_update pulse.
- Burst write cmd 8'h06, data 8'h11, 8'h22, 8'h33 -> reg 6 = 8'h11, reg 7 = 8'h22, reg 0 = 8'h33 (wrap), all committed in the same cycle.
- Read frame cmd 8'h82 after the reg 2 write -> MISO shifts 8'hA5 MSB first during data bits 0..7, then 8'h13 for the next word; no cfg_update.
- Write cmd 8'h03, data 8'h55, then 4 extra bits, then CSn rise -> reg 3 = 8'h55; frame_err and cfg_update pulse in the same cycle.
- rst_n low for 1 clk mid-word of a write to reg 4 -> reg 4 stays 8'h14, FSM returns to IDLE, the next frame behaves normally.
